psram_qspi_target: RTL and testbench

- QPI-mode PSRAM target (responder): the device-side end of the quad PSRAM link that cnn_kws_accel drives as initiator.
- Decodes quad read (0xEB) and quad write (0x38) transactions and serves them from an on-chip byte-wide SRAM port.
- Used for on-chip emulation of external PSRAM and as the bring-up and loopback partner for the accelerator's PSRAM controller.
- Oversampled design: all link inputs are synchronized into clk; psram_sck must be at most clk/4.

---
 rtl/psram_target_pkg.sv | 20 ++
 rtl/psram_link_sync.sv | 60 ++++++
 rtl/psram_qspi_target.sv | 209 ++++++++++++++++++++
 tb/tb_psram_qspi_target.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_target_pkg.sv
// Shared definitions for the QPI PSRAM target.
// Holds the supported command opcodes, the address phase length and the
// transaction state encoding used by psram_qspi_target.
package psram_target_pkg;

    localparam logic [7:0] CMD_QREAD    = 8'hEB;
    localparam logic [7:0] CMD_QWRITE   = 8'h38;
    localparam logic [2:0] ADDR_NIBBLES = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        DUMMY  = 3'd3,
        RDATA  = 3'd4,
        WDATA  = 3'd5,
        IGNORE = 3'd6
    } state_e;

endpackage

// File: rtl/psram_link_sync.sv
// Link input synchronizer for the PSRAM target.
// Brings sck, ce_n and the quad data lanes into clk through SYNC_STAGES
// flops, then produces registered one-clk edge pulses. d_sync is delayed
// by the same amount as the edge pulses, so it is the value present on
// the lanes when sck rose.
//   clk, rst          system clock, synchronous active-high reset
//   sck, ce_n, d_in   raw link inputs
//   sck_rise/fall     one-clk pulses on synchronized sck edges
//   ce_fall/rise      one-clk pulses on synchronized ce_n edges
//   d_sync            data lanes aligned with sck_rise
module psram_link_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       ce_n,
    input  logic [3:0] d_in,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic       ce_fall,
    output logic       ce_rise,
    output logic [3:0] d_sync
);

    logic [SYNC_STAGES-1:0] sck_sr;
    logic [SYNC_STAGES-1:0] ce_sr;
    logic [3:0]             d_sr [SYNC_STAGES];
    logic                   sck_prev;
    logic                   ce_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset to the idle link state so release does not fake an edge.
            sck_sr   <= '0;
            ce_sr    <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) d_sr[i] <= 4'h0;
            sck_prev <= 1'b0;
            ce_prev  <= 1'b1;
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
            ce_fall  <= 1'b0;
            ce_rise  <= 1'b0;
            d_sync   <= 4'h0;
        end else begin
            sck_sr  <= {sck_sr[SYNC_STAGES-2:0], sck};
            ce_sr   <= {ce_sr[SYNC_STAGES-2:0], ce_n};
            d_sr[0] <= d_in;
            for (int i = 1; i < SYNC_STAGES; i++) d_sr[i] <= d_sr[i-1];
            sck_prev <= sck_sr[SYNC_STAGES-1];
            ce_prev  <= ce_sr[SYNC_STAGES-1];
            sck_rise <= sck_sr[SYNC_STAGES-1] & ~sck_prev;
            sck_fall <= ~sck_sr[SYNC_STAGES-1] & sck_prev;
            ce_fall  <= ~ce_sr[SYNC_STAGES-1] & ce_prev;
            ce_rise  <= ce_sr[SYNC_STAGES-1] & ~ce_prev;
            d_sync   <= d_sr[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/psram_qspi_target.sv
// QPI-mode PSRAM target: serves quad read (0xEB) and quad write (0x38)
// bursts from a byte-wide SRAM port. All link inputs are oversampled in clk.
//   clk, rst                     system clock, synchronous active-high reset
//   psram_sck_i/ce_n_i/d_i       link from the initiator
//   psram_d_o, psram_d_oe        quad read data and lane enables
//   mem_addr/re/rdata            SRAM read port (rdata one clk after re)
//   mem_we/wdata                 SRAM write strobe and data
//   busy                         transaction in progress
//   cmd_err                      one-clk pulse on an unsupported opcode
//
// state  | meaning
// IDLE   | waiting for ce_n to fall
// CMD    | collecting the 2 opcode nibbles
// ADDR   | collecting the 6 address nibbles
// DUMMY  | counting dummy sck rises while the first byte is prefetched
// RDATA  | driving read nibbles on sck falls, prefetching the next byte
// WDATA  | pairing write nibbles into bytes and committing them
// IGNORE | unsupported opcode, waiting for ce_n to rise
module psram_qspi_target
    import psram_target_pkg::*;
#(
    parameter int MEM_AW      = 10,
    parameter int DUMMY_CYC   = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psram_sck_i,
    input  logic              psram_ce_n_i,
    input  logic [3:0]        psram_d_i,
    output logic [3:0]        psram_d_o,
    output logic [3:0]        psram_d_oe,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              cmd_err
);

    logic              sck_rise, sck_fall, ce_fall, ce_rise;
    logic [3:0]        d_sync;
    state_e            state;
    logic [2:0]        nib_cnt;
    logic [MEM_AW-1:0] shreg;      // opcode/address shifter; old bits fall off the top
    logic [MEM_AW-1:0] addr;
    logic [MEM_AW-1:0] addr_inc;
    logic [MEM_AW-1:0] addr_full;
    logic              is_write;
    logic [3:0]        dummy_cnt;
    logic [7:0]        pf_byte;
    logic              re_d;
    logic              nib_lo;     // next nibble is the low half of a byte
    logic [3:0]        wr_hi;

    psram_link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .sck      (psram_sck_i),
        .ce_n     (psram_ce_n_i),
        .d_in     (psram_d_i),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .ce_fall  (ce_fall),
        .ce_rise  (ce_rise),
        .d_sync   (d_sync)
    );

    assign addr_inc  = addr + MEM_AW'(1);
    assign addr_full = {shreg[MEM_AW-5:0], d_sync};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            psram_d_o  <= 4'h0;
            psram_d_oe <= 4'h0;
            mem_addr   <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_wdata  <= 8'h00;
            busy       <= 1'b0;
            cmd_err    <= 1'b0;
            nib_cnt    <= 3'd0;
            shreg      <= '0;
            addr       <= '0;
            is_write   <= 1'b0;
            dummy_cnt  <= 4'd0;
            pf_byte    <= 8'h00;
            re_d       <= 1'b0;
            nib_lo     <= 1'b0;
            wr_hi      <= 4'h0;
        end else begin
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            cmd_err <= 1'b0;
            re_d    <= mem_re;
            if (re_d) pf_byte <= mem_rdata;

            // ce_n rising overrides any sck edge seen in the same clk.
            if (ce_rise) begin
                state      <= IDLE;
                busy       <= 1'b0;
                psram_d_oe <= 4'h0;
                psram_d_o  <= 4'h0;
                nib_cnt    <= 3'd0;
                nib_lo     <= 1'b0;
                re_d       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ce_fall) begin
                            state   <= CMD;
                            busy    <= 1'b1;
                            nib_cnt <= 3'd0;
                        end
                    end
                    CMD: begin
                        if (sck_rise) begin
                            shreg <= addr_full;
                            if (nib_cnt == 3'd1) begin
                                nib_cnt <= 3'd0;
                                case ({shreg[3:0], d_sync})
                                    CMD_QREAD: begin
                                        state    <= ADDR;
                                        is_write <= 1'b0;
                                    end
                                    CMD_QWRITE: begin
                                        state    <= ADDR;
                                        is_write <= 1'b1;
                                    end
                                    default: begin
                                        cmd_err <= 1'b1;
                                        state   <= IGNORE;
                                    end
                                endcase
                            end else begin
                                nib_cnt <= nib_cnt + 3'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (sck_rise) begin
                            shreg <= addr_full;
                            if (nib_cnt == ADDR_NIBBLES - 3'd1) begin
                                nib_cnt <= 3'd0;
                                addr    <= addr_full;
                                nib_lo  <= 1'b0;
                                if (is_write) begin
                                    state <= WDATA;
                                end else begin
                                    mem_re    <= 1'b1;
                                    mem_addr  <= addr_full;
                                    dummy_cnt <= 4'(DUMMY_CYC);
                                    state     <= DUMMY;
                                end
                            end else begin
                                nib_cnt <= nib_cnt + 3'd1;
                            end
                        end
                    end
                    DUMMY: begin
                        if (sck_rise && dummy_cnt != 4'd0) begin
                            dummy_cnt <= dummy_cnt - 4'd1;
                        end else if (sck_fall && dummy_cnt == 4'd0) begin
                            psram_d_oe <= 4'hF;
                            psram_d_o  <= pf_byte[7:4];
                            nib_lo     <= 1'b1;
                            state      <= RDATA;
                        end
                    end
                    RDATA: begin
                        if (sck_fall) begin
                            if (nib_lo) begin
                                // pf_byte is free once its low nibble is out.
                                psram_d_o <= pf_byte[3:0];
                                nib_lo    <= 1'b0;
                                addr      <= addr_inc;
                                mem_addr  <= addr_inc;
                                mem_re    <= 1'b1;
                            end else begin
                                psram_d_o <= pf_byte[7:4];
                                nib_lo    <= 1'b1;
                            end
                        end
                    end
                    WDATA: begin
                        if (sck_rise) begin
                            if (!nib_lo) begin
                                wr_hi  <= d_sync;
                                nib_lo <= 1'b1;
                            end else begin
                                mem_we    <= 1'b1;
                                mem_addr  <= addr;
                                mem_wdata <= {wr_hi, d_sync};
                                addr      <= addr_inc;
                                nib_lo    <= 1'b0;
                            end
                        end
                    end
                    IGNORE: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psram_qspi_target.sv
// Directed bench for psram_qspi_target: acts as the link initiator and
// models the backing SRAM, logging every write and read strobe.
module tb_psram_qspi_target;

    localparam int MEM_AW = 10;
    localparam int SYNC   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              psram_sck_i = 1'b0;
    logic              psram_ce_n_i = 1'b1;
    logic [3:0]        psram_d_i = 4'h0;
    logic [3:0]        psram_d_o;
    logic [3:0]        psram_d_oe;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_re;
    logic [7:0]        mem_rdata = 8'h00;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              cmd_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]        mem [1024];
    logic [MEM_AW-1:0] we_a [$];
    logic [7:0]        we_d [$];
    logic [MEM_AW-1:0] re_a [$];
    int                err_n = 0;
    bit                oe_seen = 1'b0;

    psram_qspi_target #(.MEM_AW(MEM_AW), .DUMMY_CYC(6), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .psram_sck_i  (psram_sck_i),
        .psram_ce_n_i (psram_ce_n_i),
        .psram_d_i    (psram_d_i),
        .psram_d_o    (psram_d_o),
        .psram_d_oe   (psram_d_oe),
        .mem_addr     (mem_addr),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .cmd_err      (cmd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_a.push_back(mem_addr);
            we_d.push_back(mem_wdata);
        end
        if (mem_re) begin
            mem_rdata <= mem[mem_addr];
            re_a.push_back(mem_addr);
        end
        if (cmd_err) err_n++;
        if (psram_d_oe !== 4'h0) oe_seen = 1'b1;
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        we_a.delete();
        we_d.delete();
        re_a.delete();
        err_n   = 0;
        oe_seen = 1'b0;
    endtask

    task automatic sck_cycle(input logic [3:0] nib, input int half);
        psram_d_i = nib;
        clk_n(half);
        psram_sck_i = 1'b1;
        clk_n(half);
        psram_sck_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int half);
        sck_cycle(b[7:4], half);
        sck_cycle(b[3:0], half);
    endtask

    task automatic read_nib(output logic [3:0] n, output logic [3:0] oe, input int half);
        clk_n(half);
        n  = psram_d_o;
        oe = psram_d_oe;
        psram_sck_i = 1'b1;
        clk_n(half);
        psram_sck_i = 1'b0;
    endtask

    task automatic ce_start();
        psram_ce_n_i = 1'b0;
        clk_n(4);
    endtask

    task automatic ce_stop();
        clk_n(4);
        psram_ce_n_i = 1'b1;
        clk_n(8);
    endtask

    task automatic start_read(input logic [23:0] a, input int half);
        ce_start();
        send_byte(8'hEB, half);
        send_byte(a[23:16], half);
        send_byte(a[15:8], half);
        send_byte(a[7:0], half);
        repeat (6) sck_cycle(4'h0, half);
    endtask

    task automatic test_reset();
        logic [33:0] outs;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            psram_sck_i  = 1'($urandom);
            psram_ce_n_i = 1'($urandom);
            psram_d_i    = 4'($urandom);
            @(negedge clk);
            outs = {psram_d_o, psram_d_oe, mem_addr, mem_re, mem_we, mem_wdata, busy, cmd_err};
            n_tests++;
            if (outs !== 34'h0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, outs);
            end
        end
        psram_sck_i  = 1'b0;
        psram_ce_n_i = 1'b1;
        psram_d_i    = 4'h0;
        rst = 1'b0;
        clk_n(6);
        n_tests++;
        if ({busy, psram_d_oe} !== 5'h0) begin
            n_fail++;
            $display("FAIL reset_release: got busy=%b oe=%h expected 0/0", busy, psram_d_oe);
        end
    endtask

    task automatic test_write();
        int lat;
        clear_logs();
        ce_start();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL write_busy_high: got %b expected 1", busy);
        end
        send_byte(8'h38, 2);
        send_byte(8'h00, 2);
        send_byte(8'h00, 2);
        send_byte(8'h10, 2);
        send_byte(8'hA5, 2);
        send_byte(8'h3C, 2);
        clk_n(4);
        psram_ce_n_i = 1'b1;
        lat = 0;
        while (busy && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_tests++;
        if (busy !== 1'b0 || lat > SYNC + 2) begin
            n_fail++;
            $display("FAIL write_busy_fall: got %0d clk expected <= %0d", lat, SYNC + 2);
        end
        clk_n(4);
        n_tests++;
        if (we_a.size() != 2) begin
            n_fail++;
            $display("FAIL write_we_count: got %0d expected 2", we_a.size());
        end else begin
            n_tests++;
            if (we_a[0] !== 10'h010 || we_d[0] !== 8'hA5) begin
                n_fail++;
                $display("FAIL write_first: got %h/%h expected 010/a5", we_a[0], we_d[0]);
            end
            n_tests++;
            if (we_a[1] !== 10'h011 || we_d[1] !== 8'h3C) begin
                n_fail++;
                $display("FAIL write_second: got %h/%h expected 011/3c", we_a[1], we_d[1]);
            end
        end
        n_tests++;
        if (oe_seen) begin
            n_fail++;
            $display("FAIL write_oe: got oe active expected 0");
        end
    endtask

    task automatic test_read();
        logic [3:0] exp_n [4];
        logic [3:0] n, oe;
        exp_n = '{4'hA, 4'h5, 4'h3, 4'hC};
        clear_logs();
        mem[10'h010] = 8'hA5;
        mem[10'h011] = 8'h3C;
        start_read(24'h000010, 5);
        n_tests++;
        if (psram_d_oe !== 4'h0) begin
            n_fail++;
            $display("FAIL read_oe_before_data: got %h expected 0", psram_d_oe);
        end
        for (int i = 0; i < 4; i++) begin
            read_nib(n, oe, 5);
            n_tests++;
            if (n !== exp_n[i] || oe !== 4'hF) begin
                n_fail++;
                $display("FAIL read_nibble %0d: got %h oe=%h expected %h oe=f", i, n, oe, exp_n[i]);
            end
        end
        n_tests++;
        if (re_a.size() < 1 || re_a[0] !== 10'h010) begin
            n_fail++;
            $display("FAIL read_first_addr: got %0d strobes expected first at 010", re_a.size());
        end
        ce_stop();
        n_tests++;
        if (psram_d_oe !== 4'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL read_end: got oe=%h busy=%b expected 0/0", psram_d_oe, busy);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_n [4];
        logic [3:0] n, oe;
        exp_n = '{4'h1, 4'h1, 4'h2, 4'h2};
        clear_logs();
        mem[10'h3FF] = 8'h11;
        mem[10'h000] = 8'h22;
        start_read(24'h0003FF, 5);
        for (int i = 0; i < 4; i++) begin
            read_nib(n, oe, 5);
            n_tests++;
            if (n !== exp_n[i]) begin
                n_fail++;
                $display("FAIL wrap_nibble %0d: got %h expected %h", i, n, exp_n[i]);
            end
        end
        n_tests++;
        if (re_a.size() < 2 || re_a[0] !== 10'h3FF || re_a[1] !== 10'h000) begin
            n_fail++;
            $display("FAIL wrap_addr: got %0d strobes expected 3ff then 000", re_a.size());
        end
        ce_stop();
    endtask

    task automatic test_bad_cmd();
        clear_logs();
        ce_start();
        send_byte(8'h9F, 2);
        send_byte(8'hEB, 2);
        send_byte(8'h38, 2);
        send_byte(8'h00, 2);
        send_byte(8'h10, 2);
        ce_stop();
        n_tests++;
        if (err_n != 1) begin
            n_fail++;
            $display("FAIL bad_cmd_err: got %0d pulses expected 1", err_n);
        end
        n_tests++;
        if (re_a.size() != 0 || we_a.size() != 0 || oe_seen) begin
            n_fail++;
            $display("FAIL bad_cmd_side: got re=%0d we=%0d oe=%b expected 0/0/0",
                     re_a.size(), we_a.size(), oe_seen);
        end
    endtask

    task automatic test_abort_write();
        clear_logs();
        ce_start();
        send_byte(8'h38, 2);
        send_byte(8'h00, 2);
        send_byte(8'h00, 2);
        send_byte(8'h00, 2);
        sck_cycle(4'hA, 2);
        sck_cycle(4'h5, 2);
        sck_cycle(4'hC, 2);
        ce_stop();
        clk_n(8);
        n_tests++;
        if (we_a.size() != 1) begin
            n_fail++;
            $display("FAIL abort_we_count: got %0d expected 1", we_a.size());
        end else begin
            n_tests++;
            if (we_a[0] !== 10'h000 || we_d[0] !== 8'hA5) begin
                n_fail++;
                $display("FAIL abort_we: got %h/%h expected 000/a5", we_a[0], we_d[0]);
            end
        end
    endtask

    task automatic test_reset_rdata();
        logic [3:0] n, oe;
        int re_before;
        clear_logs();
        mem[10'h010] = 8'hA5;
        start_read(24'h000010, 5);
        read_nib(n, oe, 5);
        n_tests++;
        if (n !== 4'hA || oe !== 4'hF) begin
            n_fail++;
            $display("FAIL rst_rdata_pre: got %h oe=%h expected a oe=f", n, oe);
        end
        re_before = re_a.size();
        rst = 1'b1;
        psram_ce_n_i = 1'b1;
        @(negedge clk);
        n_tests++;
        if (psram_d_oe !== 4'h0 || busy !== 1'b0 || psram_d_o !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_rdata_oe: got oe=%h busy=%b d=%h expected 0/0/0",
                     psram_d_oe, busy, psram_d_o);
        end
        clk_n(2);
        rst = 1'b0;
        clk_n(8);
        n_tests++;
        if (re_a.size() != re_before || busy !== 1'b0 || psram_d_oe !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_rdata_idle: got re=%0d busy=%b oe=%h expected re=%0d 0/0",
                     re_a.size(), busy, psram_d_oe, re_before);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_bad_cmd();
        test_abort_write();
        test_reset_rdata();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
